rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-port arbiter for the 32x32 register file. It shares the single write port (data, address, write enable) between the in-order pipeline writeback stage and the multi-cycle mul/div (M-extension) unit. Mul/div results are held in a one-entry buffer. The block exports pending-destination information to hazard logic and, optionally, stalls the pipeline to prevent starvation.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- STARVE_LIMIT, 4, consecutive lost arbitration cycles before the held mul/div result is forced in (range 1..15)

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- PIPE_VALID  in  1  pipeline writeback request this cycle
- PIPE_ADDR  in  ADDR_W  pipeline destination register
- PIPE_DATA  in  DATA_W  pipeline result
- MD_VALID  in  1  mul/div result valid
- MD_READY  out  1  arbiter can accept a mul/div result
- MD_ADDR  in  ADDR_W  mul/div destination register
- MD_DATA  in  DATA_W  mul/div result
- RF_IN  out  DATA_W  to the register file data input
- RF_INADDRESS  out  ADDR_W  to the register file write address
- RF_WRITE_EN  out  1  to the register file write enable
- PIPE_STALL  out  1  pipeline must hold its writeback stage
- MD_PENDING  out  1  the buffer holds an unwritten mul/div result
- PENDING_ADDR  out  ADDR_W  destination of the held result; 0 when empty

## Operation
- One-entry hold buffer: holds valid, addr, data. MD_READY = ~buffer valid, driven from a register.
- A mul/div transfer occurs when MD_VALID & MD_READY at a rising edge. The buffer loads MD_ADDR/MD_DATA.
- FSM states:
  - IDLE: buffer empty.
  - HELD: buffer full.
  - FORCE: buffer full, starvation limit reached.
- IDLE -> HELD on a transfer.
- HELD:
  - If PIPE_VALID, the pipeline wins and the starvation counter increments. When the counter reaches STARVE_LIMIT, go to FORCE.
  - If PIPE_VALID=0, the buffer drains, the counter clears, and the FSM goes to IDLE.
- FORCE: the buffer drains unconditionally, the counter clears, and the FSM goes to IDLE. PIPE_VALID is ignored this cycle.
- The pipeline wins in every state except FORCE.
- Destination register 0: the grant and buffer drain proceed normally, but RF_WRITE_EN stays 0.
- MD_PENDING = buffer valid. PENDING_ADDR = buffered address when valid, else 0. Hazard logic stalls reads of that register.
- Drain and capture never happen in the same cycle. MD_READY is 0 whenever the buffer is full.

## Timing
- RF_IN, RF_INADDRESS and RF_WRITE_EN are registered: a grant in cycle N drives them in cycle N+1, and the register file commits at the end of N+1.
- Mul/div capture-to-drain latency is at least 1 cycle, so throughput is at most one mul/div result per 2 cycles.
- PIPE_STALL is a Moore output: high exactly for the cycle(s) the FSM is in FORCE.
- RESET (any cycle, including mid-hold):
  - FSM -> IDLE, buffer invalidated, counter = 0; any held result is discarded.
  - RF_WRITE_EN = 0, RF_IN = 0, RF_INADDRESS = 0, PIPE_STALL = 0, MD_PENDING = 0, PENDING_ADDR = 0.
  - MD_READY = 1 in the first cycle after reset.

## Configuration
- RF_ARB_ANTISTARVE_EN defined: FORCE state, starvation counter and PIPE_STALL logic are compiled in, as described above.
- Not defined:
  - No FORCE state and no counter; PIPE_STALL is tied 0 and STARVE_LIMIT is unused.
  - The buffer drains only in cycles with PIPE_VALID=0, so the pipeline has strict priority.

## Structure
- Package rf_arb_pkg holds:
  - the FSM state enum (IDLE, HELD, FORCE);
  - DATA_W and ADDR_W defaults;
  - the counter width constant (4 bits).
- Sub-module rf_wb_holdbuf implements the one-entry buffer: load, drain, valid, addr and data, with MD_READY generation.
- The top level holds the FSM, counter, grant mux and output registers.

## Test plan
- Pipeline-only: PIPE_VALID=1, addr 5, data 0xDEADBEEF in cycle 0 -> RF_WRITE_EN=1, RF_INADDRESS=5, RF_IN=0xDEADBEEF in cycle 1; MD_READY stays 1.
- Mul/div in idle slot: MD_VALID=1, addr 7, data 0x12345678, PIPE_VALID=0 -> MD_PENDING=1, PENDING_ADDR=7, MD_READY=0 next cycle. Then RF_WRITE_EN=1 at addr 7 one cycle later, and MD_PENDING returns to 0.
- Contention with macro: buffer holds addr 3, PIPE_VALID=1 continuously, STARVE_LIMIT=4 -> 4 pipeline writes, then PIPE_STALL=1 for 1 cycle. The addr 3 write appears the next cycle, and pipeline writes resume.
- Contention without macro: same stimulus -> PIPE_STALL never asserts and addr 3 remains pending. It is written one cycle after the first PIPE_VALID=0 cycle.
- x0 suppression: pipeline write to addr 0 and mul/div result to addr 0 -> RF_WRITE_EN stays 0 for both, and the buffer still empties (MD_READY back to 1).
- Reset mid-hold: buffer holds addr 9, RESET=1 for one cycle -> all outputs 0 except MD_READY=1; no write to addr 9 ever occurs.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The anti-starvation feature is selected with the RF_ARB_ANTISTARVE_EN macro.
package rf_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rf_wb_holdbuf.sv
// One-entry hold buffer for a mul/div writeback result.
// MD_READY comes straight from a register, so it never depends on the same-cycle MD_VALID.
module rf_wb_holdbuf
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // The address is cleared on drain so it reads as 0 whenever the buffer is empty.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_addr  <= '0;
    end else if (i_drain) begin
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_addr  <= '0;
    end else if (i_load && r_ready) begin
      r_valid <= 1'b1;
      r_ready <= 1'b0;
      r_addr  <= i_addr;
    end
  end

  // NOTE: the data payload has no reset; it is only observed while r_valid is set.
  always_ff @(posedge CLK) begin
    if (i_load && r_ready && !i_drain) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ready = r_ready;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and the mul/div unit.
// Define RF_ARB_ANTISTARVE_EN to compile in the FORCE state, starvation counter and PIPE_STALL.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PIPE_VALID,
  input  logic [ADDR_W-1:0] PIPE_ADDR,
  input  logic [DATA_W-1:0] PIPE_DATA,
  input  logic              MD_VALID,
  output logic              MD_READY,
  input  logic [ADDR_W-1:0] MD_ADDR,
  input  logic [DATA_W-1:0] MD_DATA,
  output logic [DATA_W-1:0] RF_IN,
  output logic [ADDR_W-1:0] RF_INADDRESS,
  output logic              RF_WRITE_EN,
  output logic              PIPE_STALL,
  output logic              MD_PENDING,
  output logic [ADDR_W-1:0] PENDING_ADDR
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("rf_wb_arbiter: STARVE_LIMIT must be in 1..15");
  end

  arb_state_e        r_state;
  logic [DATA_W-1:0] r_rf_in;
  logic [ADDR_W-1:0] r_rf_addr;
  logic              r_rf_we;

  logic              w_load;
  logic              w_drain;
  logic              w_buf_valid;
  logic              w_md_ready;
  logic [ADDR_W-1:0] w_buf_addr;
  logic [DATA_W-1:0] w_buf_data;

  // Capture is only possible while empty, drain only while full: never both at once.
  assign w_load  = MD_VALID && w_md_ready;
  assign w_drain = ((r_state == HELD) && !PIPE_VALID) || (r_state == FORCE);

  rf_wb_holdbuf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_holdbuf (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_load  (w_load),
    .i_drain (w_drain),
    .i_addr  (MD_ADDR),
    .i_data  (MD_DATA),
    .o_valid (w_buf_valid),
    .o_ready (w_md_ready),
    .o_addr  (w_buf_addr),
    .o_data  (w_buf_data)
  );

`ifdef RF_ARB_ANTISTARVE_EN
  localparam logic [CNT_W-1:0] STARVE_CMP = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_stall;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_rf_in   <= '0;
      r_rf_addr <= '0;
      r_rf_we   <= 1'b0;
`ifdef RF_ARB_ANTISTARVE_EN
      r_cnt     <= '0;
      r_stall   <= 1'b0;
`endif
    end else begin
      // Grant mux: a drained result beats the pipeline; writes to x0 are suppressed.
      r_rf_we <= 1'b0;
      if (w_drain) begin
        r_rf_in   <= w_buf_data;
        r_rf_addr <= w_buf_addr;
        r_rf_we   <= (w_buf_addr != '0);
      end else if (PIPE_VALID) begin
        r_rf_in   <= PIPE_DATA;
        r_rf_addr <= PIPE_ADDR;
        r_rf_we   <= (PIPE_ADDR != '0);
      end

      case (r_state)
        IDLE: begin
          if (w_load) r_state <= HELD;
        end
        HELD: begin
          if (!PIPE_VALID) r_state <= IDLE;
`ifdef RF_ARB_ANTISTARVE_EN
          if (!PIPE_VALID) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if ((r_cnt + 1'b1) == STARVE_CMP) begin
              r_state <= FORCE;
              r_stall <= 1'b1;
            end
          end
`endif
        end
`ifdef RF_ARB_ANTISTARVE_EN
        FORCE: begin
          r_state <= IDLE;
          r_stall <= 1'b0;
          r_cnt   <= '0;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign RF_IN        = r_rf_in;
  assign RF_INADDRESS = r_rf_addr;
  assign RF_WRITE_EN  = r_rf_we;
  assign MD_READY     = w_md_ready;
  assign MD_PENDING   = w_buf_valid;
  assign PENDING_ADDR = w_buf_addr;

`ifdef RF_ARB_ANTISTARVE_EN
  assign PIPE_STALL = r_stall;
`else
  assign PIPE_STALL = 1'b0;
`endif

endmodule
